// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: stall/flush control for the 5-stage pipeline.
// It covers the hazards that forwarding cannot resolve: load-use, and branch
// operands that are not ready in ID. It also flushes IF/ID on taken branches
// and jumps, and keeps saturating counters of stall cycles and flushes.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RUN          | normal issue; hazards are evaluated combinationally
// STALL_EXTRA  | second bubble of a branch that depends on a load in EX
module hazard_detection_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_usesRt,
    input  logic             IFID_branch,
    input  logic             IFID_jump,
    input  logic             branch_taken,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_regWrite,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       EXMEM_rd,
    input  logic             EXMEM_MemRead,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN         = 1'b0,
        STALL_EXTRA = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic src_a, src_b;
    logic hit_ex, hit_mem;
    logic haz_lu, haz_br1, haz_br2;

    // Source-register matches against EX and MEM destinations; r0 never matches.
    always_comb begin
        src_a   = (IFID_rs != 5'd0);
        src_b   = IFID_usesRt && (IFID_rt != 5'd0);
        hit_ex  = (src_a && (IDEX_rd == IFID_rs))  || (src_b && (IDEX_rd == IFID_rt));
        hit_mem = (src_a && (EXMEM_rd == IFID_rs)) || (src_b && (EXMEM_rd == IFID_rt));
        haz_lu  = IDEX_MemRead && hit_ex && !IFID_branch;
        haz_br1 = IFID_branch &&
                  ((IDEX_regWrite && !IDEX_MemRead && hit_ex) || (EXMEM_MemRead && hit_mem));
        haz_br2 = IFID_branch && IDEX_MemRead && hit_ex;
    end

    // Next state and pipeline controls; a stall always wins over a flush.
    always_comb begin
        state_d     = RUN;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        if (!Reset) begin
            case (state_q)
                RUN: begin
                    if (haz_lu || haz_br1 || haz_br2) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                        if (haz_br2) begin
                            state_d = STALL_EXTRA;
                        end
                    end else begin
                        IFID_flush = IFID_jump || (IFID_branch && branch_taken);
                    end
                end
                STALL_EXTRA: begin
                    PC_write    = 1'b0;
                    IFID_write  = 1'b0;
                    IDEX_bubble = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating performance counters; they hold once all ones.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (IDEX_bubble && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (IFID_flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= RUN;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; the counterpart of the forwarding unit.
- Forwarding resolves hazards by bypassing data. This block covers the cases bypassing cannot resolve: load-use hazards and branch operands that are not yet ready in ID. It freezes PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken branches and jumps.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of the stall_count and flush_count performance counters

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  synchronous, active-high reset
IFID_rs  input  5  rs field of the instruction in ID
IFID_rt  input  5  rt field of the instruction in ID
IFID_usesRt  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
IFID_branch  input  1  ID instruction is a conditional branch (compared in ID)
IFID_jump  input  1  ID instruction is j/jal/jr
branch_taken  input  1  ID comparator result, valid when IFID_branch=1
IDEX_rd  input  5  destination register of the EX instruction (after RegDst mux)
IDEX_regWrite  input  1  EX instruction writes the register file
IDEX_MemRead  input  1  EX instruction is a load
EXMEM_rd  input  5  destination register of the MEM instruction
EXMEM_MemRead  input  1  MEM instruction is a load
PC_write  output  1  1 = PC may update; 0 = hold
IFID_write  output  1  1 = IF/ID may load; 0 = hold
IDEX_bubble  output  1  1 = zero all ID/EX control bits this cycle
IFID_flush  output  1  1 = IF/ID loads a NOP at the next edge
stall_count  output  CNT_W  stall cycles since reset, saturating
flush_count  output  CNT_W  flushes since reset, saturating

Behaviour:
- Match definitions:
  - srcA = (IFID_rs != 0).
  - srcB = IFID_usesRt && (IFID_rt != 0).
  - hitEX = IDEX_rd matches a valid source.
  - hitMEM = EXMEM_rd matches a valid source.
  - Register 0 never causes a hazard.
- Hazard classes, evaluated combinationally in state RUN:
  - LU (1 cycle): IDEX_MemRead && hitEX && !IFID_branch.
  - BR1 (1 cycle): IFID_branch && ((IDEX_regWrite && !IDEX_MemRead && hitEX) || (EXMEM_MemRead && hitMEM)).
  - BR2 (2 cycles): IFID_branch && IDEX_MemRead && hitEX.
- FSM states: RUN, STALL_EXTRA.
  - RUN with any hazard: in the same cycle drive PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0.
  - RUN with BR2: next state is STALL_EXTRA. All other cases stay in RUN.
  - STALL_EXTRA: unconditionally drive PC_write=0, IFID_write=0, IDEX_bubble=1; all inputs are ignored; next state is RUN.
  - RUN with no hazard: PC_write=1, IFID_write=1, IDEX_bubble=0; IFID_flush = IFID_jump || (IFID_branch && branch_taken).
- Priority: a stall always beats a flush. branch_taken is ignored while stalling because the operands are stale. The flush is issued in the first non-stall cycle.
- Counters:
  - stall_count increments by 1 on every clock edge where IDEX_bubble=1.
  - flush_count increments on every edge where IFID_flush=1.
  - Both saturate at all-ones; they do not wrap.
- Reset:
  - While Reset=1, outputs are forced combinationally to PC_write=1, IFID_write=1, IDEX_bubble=0, IFID_flush=0, and counters do not increment.
  - At the clock edge with Reset=1, the state goes to RUN and both counters go to 0.
  - Reset asserted in STALL_EXTRA aborts the stall; the next state is RUN.
- Outputs carry no latency beyond the state register; all hazard decisions are same-cycle combinational.

Test Plan:
- Reset=1 for 2 cycles with hazard inputs active (IDEX_MemRead=1, IDEX_rd=IFID_rs=3) -> PC_write=1, IFID_write=1, IDEX_bubble=0, IFID_flush=0, stall_count=0, flush_count=0.
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs=5, IFID_branch=0 -> stall for exactly 1 cycle; next cycle with IDEX_MemRead=0 -> run; stall_count=1. Same stimulus with rd=rs=0 -> no stall.
- BR2: IFID_branch=1, IDEX_MemRead=1, IDEX_rd=IFID_rt=7, IFID_usesRt=1, branch_taken=1 -> 2 stall cycles (second cycle in STALL_EXTRA even if inputs clear), then IFID_flush=1 for 1 cycle; stall_count=2, flush_count=1.
- BR1: IFID_branch=1, IDEX_regWrite=1, IDEX_MemRead=0, IDEX_rd=IFID_rs=4 -> 1 stall cycle; EXMEM_MemRead=1, EXMEM_rd=IFID_rs=4 -> 1 stall cycle. IFID_usesRt=0 with rd=rt match -> no stall.
- Jump with no hazard: IFID_jump=1 -> IFID_flush=1 and PC_write=1 in the same cycle; flush_count increments by 1.
- Saturation and abort: CNT_W=2, hold a load-use hazard for 5 cycles -> stall_count reaches 3 and holds. Then assert Reset during STALL_EXTRA -> state returns to RUN, counters read 0.
